// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter with bounded hold sharing one data memory port between two requesters.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int HOLD_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_e;

    localparam logic [3:0] HM = 4'(HOLD_MAX);

    owner_e        owner_q, owner_d;
    logic          last_q, last_d;
    logic [3:0]    hold_q, hold_d;
    logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic          g0, g1;

    // Grants are masked during reset so nothing reaches the memory while it is asserted.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        case (owner_q)
            OWN0: begin
                g0 = m0_req && (!m1_req || hold_q < HM);
                g1 = !g0 && m1_req;
            end
            OWN1: begin
                g1 = m1_req && (!m0_req || hold_q < HM);
                g0 = !g1 && m0_req;
            end
            default: begin
                g0 = m0_req && (!m1_req || last_q);
                g1 = m1_req && (!m0_req || !last_q);
            end
        endcase
        if (reset) begin
            g0 = 1'b0;
            g1 = 1'b0;
        end
    end

    assign m0_gnt    = g0;
    assign m1_gnt    = g1;
    assign mem_we    = g0 ? m0_we : g1 ? m1_we : 1'b0;
    assign mem_a     = g0 ? m0_addr : g1 ? m1_addr : '0;
    assign mem_wd    = g0 ? m0_wdata : g1 ? m1_wdata : '0;
    assign m0_rvalid = rvalid0_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rvalid = rvalid1_q;
    assign m1_rdata  = rdata1_q;

    always_comb begin
        owner_d   = IDLE;
        hold_d    = 4'd0;
        last_d    = last_q;
        rvalid0_d = g0 && !m0_we;
        rvalid1_d = g1 && !m1_we;
        rdata0_d  = rvalid0_d ? mem_rd : rdata0_q;
        rdata1_d  = rvalid1_d ? mem_rd : rdata1_q;
        if (g0 || g1) begin
            last_d  = g1;
            owner_d = g1 ? OWN1 : OWN0;
            hold_d  = (owner_d == owner_q) ? ((hold_q < HM) ? hold_q + 4'd1 : HM) : 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q   <= IDLE;
            last_q    <= 1'b1;
            hold_q    <= 4'd0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            owner_q   <= owner_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table plus hand sequences for dmem_arbiter, with a behavioural memory.
module tb_dmem_arbiter;
    logic        clk = 1'b0, reset = 1'b1;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we;
    logic [31:0] m0_rdata, m1_rdata, mem_a, mem_wd, mem_rd;
    logic [31:0] mem [64];
    int          n_vec = 0, errs = 0;

    typedef struct {
        logic rs, r0, w0; logic [31:0] a0, d0;
        logic r1, w1;     logic [31:0] a1, d1;
        logic g0, g1, mwe; logic [31:0] ma, mwd;
        logic v0; logic [31:0] q0; logic v1; logic [31:0] q1;
    } vec_t;
    vec_t vecs[$];

    dmem_arbiter #(.AW(32), .DW(32), .HOLD_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[7:2]];
    always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;

    task automatic drive(input logic rs, r0, w0, input logic [31:0] a0, d0,
                         input logic r1, w1, input logic [31:0] a1, d1);
        @(posedge clk);
        #1;
        reset = rs; m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        @(negedge clk);
        n_vec++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, exp);
        if (act !== exp) begin
            errs++;
            $display("FAIL %s (vector %0d): got %h, expected %h", nm, n_vec, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);
        mem[4] = 32'hDEAD_BEEF;

        // Reset state
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_gnt0", {31'd0, m0_gnt}, 0);
        chk("rst_rvalid0", {31'd0, m0_rvalid}, 0);
        chk("rst_rdata1", m1_rdata, 0);
        chk("rst_mem_we", {31'd0, mem_we}, 0);

        // Tie right after reset goes to m0, then single accesses alternate m0, m1, m0
        drive(0, 1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
        chk("tie_g0", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        drive(0, 0, 0, 0, 0, 1, 0, 32'h4, 0);
        chk("alt_g1", {30'd0, m1_gnt, m0_gnt}, 32'd2);
        drive(0, 1, 0, 32'h8, 0, 0, 0, 0, 0);
        chk("alt_g0", {30'd0, m1_gnt, m0_gnt}, 32'd1);

        // Bounded hold: both streaming, m0 gets 4 grants then m1 takes over
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 6; c++) begin
            drive(0, 1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
            chk($sformatf("hold_c%0d", c), {30'd0, m1_gnt, m0_gnt}, (c < 4) ? 32'd1 : 32'd2);
        end

        // m0 streams 10 reads with no gaps, rvalid in order one cycle later
        for (int i = 0; i < 11; i++) begin
            if (i < 10) drive(0, 1, 0, 32'(4 * i), 0, 0, 0, 0, 0);
            else        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            if (i < 10) begin
                chk($sformatf("strm_gnt%0d", i), {31'd0, m0_gnt}, 1);
                chk($sformatf("strm_addr%0d", i), mem_a, 32'(4 * i));
            end
            if (i > 0) begin
                chk($sformatf("strm_rv%0d", i), {31'd0, m0_rvalid}, 1);
                chk($sformatf("strm_rd%0d", i), m0_rdata,
                    (i - 1 == 4) ? 32'hDEAD_BEEF : 32'hA000_0000 + 32'(i - 1));
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("strm_rv_end", {31'd0, m0_rvalid}, 0);

        // Reset right after a granted read suppresses rvalid and blocks the write
        drive(0, 1, 0, 32'h10, 0, 0, 0, 0, 0);
        chk("rr_gnt", {31'd0, m0_gnt}, 1);
        drive(1, 0, 0, 0, 0, 1, 1, 32'h30, 32'h0BAD_0BAD);
        chk("rr_rvalid", {31'd0, m0_rvalid}, 0);
        chk("rr_rdata", m0_rdata, 0);
        chk("rr_mem_we", {31'd0, mem_we}, 0);
        chk("rr_gnt1", {31'd0, m1_gnt}, 0);
        drive(0, 1, 0, 32'h30, 0, 1, 0, 32'h4, 0);
        chk("rr_tie", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rr_nowrite", m0_rdata, 32'hA000_000C);

        // rs r0 w0 a0 d0 | r1 w1 a1 d1 | g0 g1 mwe ma mwd | v0 q0 v1 q1
        vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h10, 32'h55, 1'b0, 1'b0, 32'h0, 32'h0,
                         1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                         1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                         1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                         1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0,
                         1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                         1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'hA000_0001});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h1234_5678,
                         1'b0, 1'b1, 1'b1, 32'h20, 32'h1234_5678, 1'b1, 32'hA000_0000, 1'b0, 32'hA000_0001});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h22, 32'hCAFE_0000, 1'b0, 1'b0, 32'h0, 32'h0,
                         1'b1, 1'b0, 1'b0, 32'h22, 32'hCAFE_0000, 1'b0, 32'hA000_0000, 1'b0, 32'hA000_0001});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                         1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 32'hA000_0001});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                         1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h1234_5678, 1'b0, 32'hA000_0001});

        foreach (vecs[k]) begin
            drive(vecs[k].rs, vecs[k].r0, vecs[k].w0, vecs[k].a0, vecs[k].d0,
                  vecs[k].r1, vecs[k].w1, vecs[k].a1, vecs[k].d1);
            chk($sformatf("t%0d_gnt0", k), {31'd0, m0_gnt}, {31'd0, vecs[k].g0});
            chk($sformatf("t%0d_gnt1", k), {31'd0, m1_gnt}, {31'd0, vecs[k].g1});
            chk($sformatf("t%0d_mem_we", k), {31'd0, mem_we}, {31'd0, vecs[k].mwe});
            chk($sformatf("t%0d_mem_a", k), mem_a, vecs[k].ma);
            chk($sformatf("t%0d_mem_wd", k), mem_wd, vecs[k].mwd);
            chk($sformatf("t%0d_rvalid0", k), {31'd0, m0_rvalid}, {31'd0, vecs[k].v0});
            chk($sformatf("t%0d_rdata0", k), m0_rdata, vecs[k].q0);
            chk($sformatf("t%0d_rvalid1", k), {31'd0, m1_rvalid}, {31'd0, vecs[k].v1});
            chk($sformatf("t%0d_rdata1", k), m1_rdata, vecs[k].q1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, errs);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter that shares the single-port data memory (combinational read, write on clk rising edge) between requester 0 (CPU load/store port) and requester 1 (DMA/debug loader).
- Grants at most one access per cycle using round-robin with a bounded hold counter, so neither requester starves.
- Drives the memory port combinationally from the winner and returns registered read data one cycle after grant.

Parameters:
- AW, 32, address width (byte address; memory uses a[AW-1:2]).
- DW, 32, data width.
- HOLD_MAX, 4, max consecutive grants to one requester while the other is requesting; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- m0_req  in  1  requester 0 access request; held stable until m0_gnt.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  AW  byte address.
- m0_wdata  in  DW  write data.
- m0_gnt  out  1  access accepted this cycle (combinational).
- m0_rvalid  out  1  read data valid (registered).
- m0_rdata  out  DW  read data (registered).
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0_*, for requester 1.
- mem_we  out  1  memory write enable.
- mem_a  out  AW  memory address.
- mem_wd  out  DW  memory write data.
- mem_rd  in  DW  memory combinational read data.

Behaviour:
- State: owner register in {IDLE, OWN0, OWN1}, last_winner bit, hold_cnt (4 bits).
- Reset (async) values: owner=IDLE, last_winner=1 (m0 wins first tie), hold_cnt=0, m0/m1_rvalid=0, m0/m1_rdata=0.
- Grant decision is combinational from owner, hold_cnt and the req inputs:
  - IDLE, single requester: that requester wins.
  - IDLE, both request: the one != last_winner wins.
  - OWN0: m0 wins again if m0_req && (!m1_req || hold_cnt < HOLD_MAX). Else m1 wins if m1_req. Else no grant.
  - OWN1: symmetric.
- At most one gnt is high per cycle. mX_gnt=1 only when mX_req=1.
- Memory port:
  - Winner present: mem_a = winner addr, mem_wd = winner wdata, mem_we = winner we.
  - No winner: mem_we=0, mem_a=0, mem_wd=0.
- Registered updates on each clk edge:
  - Winner same as owner: hold_cnt = min(hold_cnt+1, HOLD_MAX).
  - Winner differs from owner, or owner was IDLE: owner = OWNwinner, hold_cnt = 1.
  - Any grant: last_winner = winner.
  - No grant: owner = IDLE, hold_cnt = 0; last_winner unchanged.
- Read return:
  - Granted read (we=0): next cycle mX_rvalid=1 and mX_rdata = mem_rd sampled at the grant edge. Latency is 1 cycle.
  - mX_rvalid is a one-cycle pulse. mX_rdata holds its value until the next read by that requester.
  - Writes never assert rvalid. The write takes effect at the grant edge.
- Back-to-back grants to the same requester give one rvalid per read, in order, with no bubbles.
- Write then read of the same address on consecutive cycles returns the new data.
- Request dropped before grant: no access occurs; no error.
- Reset asserted mid-operation: a pending rvalid is suppressed, all outputs return to reset values immediately, and no memory write occurs while reset is high (mem_we forced 0).
- Address bits [1:0] pass through unchanged. Alignment is the memory's concern.

Test Plan:
- Reset, then m0 reads addr 0x10 where mem holds 0xDEADBEEF -> m0_gnt=1 in same cycle; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF; m1 outputs stay 0.
- Both request in the first cycle after reset -> m0 granted first (last_winner=1). Both held with single accesses -> grants alternate m0, m1, m0.
- m0 and m1 both request continuously, HOLD_MAX=4, starting from OWN0 with m0 streaming -> m0 gets exactly 4 consecutive grants, then m1 is granted on the 5th cycle.
- m1 writes 0x12345678 to 0x20, then m0 reads 0x20 the next cycle -> m0_rdata=0x12345678. No rvalid for the write.
- m0 alone requests 10 consecutive reads 0x0..0x24 -> 10 grants and 10 in-order rvalid pulses; hold_cnt saturates at 4 with no forced gaps.
- Assert reset in the cycle after a granted read -> m0_rvalid stays 0, mem_we=0, owner IDLE; after release, m0 wins the first tie again.
